wb_register_bank: RTL and testbench

- Write-back end of the MEM/WB boundary: consumes the MEM/WB control/data bus, selects memory vs ALU result, and commits it to the general-purpose register file.
- Serves two combinational read ports to the decode stage.
- Provides a handshaked sequential register-dump channel for the debug unit.

---
 rtl/wb_register_bank.sv | 134 +++++++++++++
 tb/tb_wb_register_bank.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_register_bank.sv
// Write-back register bank: MEM/WB result commit, two combinational read ports,
// and a ready/valid register-dump channel. Optional macro: REGBANK_WR_BYPASS_EN.
module wb_register_bank #(
    parameter int BUS_SIZE      = 32,
    parameter int REG_COUNT     = 32,
    parameter int REG_ADDR_SIZE = 5
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_enable,
    input  logic                     i_wb,
    input  logic                     i_mem_to_reg,
    input  logic [BUS_SIZE-1:0]      i_mem_result,
    input  logic [BUS_SIZE-1:0]      i_alu_result,
    input  logic [REG_ADDR_SIZE-1:0] i_addr_wr,
    input  logic [REG_ADDR_SIZE-1:0] i_addr_a,
    input  logic [REG_ADDR_SIZE-1:0] i_addr_b,
    output logic [BUS_SIZE-1:0]      o_data_a,
    output logic [BUS_SIZE-1:0]      o_data_b,
    input  logic                     i_dump_start,
    input  logic                     i_dump_ready,
    output logic                     o_dump_valid,
    output logic [REG_ADDR_SIZE-1:0] o_dump_index,
    output logic [BUS_SIZE-1:0]      o_dump_data,
    output logic                     o_dump_done
);

    // state | meaning
    // IDLE  | waiting for i_dump_start
    // SEND  | presenting reg[idx] until the consumer accepts it
    // DONE  | one-cycle completion pulse, then back to IDLE
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    logic [BUS_SIZE-1:0]      reg_q [REG_COUNT];
    logic [BUS_SIZE-1:0]      reg_d [REG_COUNT];
    logic [BUS_SIZE-1:0]      wr_data;
    logic                     wr_en;
    state_t                   state_q, state_d;
    logic [REG_ADDR_SIZE-1:0] idx_q, idx_d;

    assign wr_data = i_mem_to_reg ? i_mem_result : i_alu_result;
    assign wr_en   = i_enable && i_wb && (i_addr_wr != '0);

    always_comb begin
        reg_d = reg_q;
        if (wr_en) begin
            reg_d[i_addr_wr] = wr_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                reg_q[i] <= '0;
            end
        end else begin
            reg_q <= reg_d;
        end
    end

    // Index 0 is forced to zero on read as well, so it never depends on reg_q[0].
    always_comb begin
        o_data_a = '0;
        o_data_b = '0;
        if (i_addr_a != '0) begin
            o_data_a = reg_q[i_addr_a];
`ifdef REGBANK_WR_BYPASS_EN
            if (wr_en && (i_addr_a == i_addr_wr)) begin
                o_data_a = wr_data;
            end
`endif
        end
        if (i_addr_b != '0) begin
            o_data_b = reg_q[i_addr_b];
`ifdef REGBANK_WR_BYPASS_EN
            if (wr_en && (i_addr_b == i_addr_wr)) begin
                o_data_b = wr_data;
            end
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                idx_d = '0;
                if (i_dump_start) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (i_dump_ready) begin
                    if (idx_q == REG_ADDR_SIZE'(REG_COUNT - 1)) begin
                        state_d = ST_DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + REG_ADDR_SIZE'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Dump data is the stored value only; bypass never applies here.
    assign o_dump_valid = (state_q == ST_SEND);
    assign o_dump_done  = (state_q == ST_DONE);
    assign o_dump_index = idx_q;
    assign o_dump_data  = (state_q == ST_SEND) ? reg_q[idx_q] : '0;

endmodule

// File: tb/tb_wb_register_bank.sv
// Directed bench for wb_register_bank: vector table for write/read behaviour,
// hand sequences for bypass timing, dump streaming, backpressure and reset abort.
module tb_wb_register_bank;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_enable;
    logic        i_wb;
    logic        i_mem_to_reg;
    logic [31:0] i_mem_result;
    logic [31:0] i_alu_result;
    logic [4:0]  i_addr_wr;
    logic [4:0]  i_addr_a;
    logic [4:0]  i_addr_b;
    logic [31:0] o_data_a;
    logic [31:0] o_data_b;
    logic        i_dump_start;
    logic        i_dump_ready;
    logic        o_dump_valid;
    logic [4:0]  o_dump_index;
    logic [31:0] o_dump_data;
    logic        o_dump_done;

    int n_checks = 0;
    int n_fail   = 0;

    wb_register_bank dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_enable     (i_enable),
        .i_wb         (i_wb),
        .i_mem_to_reg (i_mem_to_reg),
        .i_mem_result (i_mem_result),
        .i_alu_result (i_alu_result),
        .i_addr_wr    (i_addr_wr),
        .i_addr_a     (i_addr_a),
        .i_addr_b     (i_addr_b),
        .o_data_a     (o_data_a),
        .o_data_b     (o_data_b),
        .i_dump_start (i_dump_start),
        .i_dump_ready (i_dump_ready),
        .o_dump_valid (o_dump_valid),
        .o_dump_index (o_dump_index),
        .o_dump_data  (o_dump_data),
        .o_dump_done  (o_dump_done)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        en;
        logic        wb;
        logic        m2r;
        logic [31:0] mem;
        logic [31:0] alu;
        logic [4:0]  addr_wr;
        logic [4:0]  addr_a;
        logic [4:0]  addr_b;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    vec_t vecs [8];
    logic [31:0] model [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] data);
        @(negedge i_clk);
        i_enable     = 1'b1;
        i_wb         = 1'b1;
        i_mem_to_reg = 1'b0;
        i_addr_wr    = addr;
        i_alu_result = data;
        @(posedge i_clk);
        #1 i_wb = 1'b0;
    endtask

    initial begin
        i_reset      = 1'b1;
        i_enable     = 1'b0;
        i_wb         = 1'b0;
        i_mem_to_reg = 1'b0;
        i_mem_result = '0;
        i_alu_result = '0;
        i_addr_wr    = '0;
        i_addr_a     = '0;
        i_addr_b     = '0;
        i_dump_start = 1'b0;
        i_dump_ready = 1'b0;

        //            en  wb  m2r mem           alu           wr  a   b   exp_a         exp_b
        vecs[0] = '{1'b1,1'b1,1'b0,32'h0,        32'h0000_00AA,5'd5, 5'd5, 5'd0, 32'h0000_00AA,32'h0};
        vecs[1] = '{1'b1,1'b1,1'b1,32'h1234_5678,32'h0,        5'd6, 5'd6, 5'd5, 32'h1234_5678,32'h0000_00AA};
        vecs[2] = '{1'b1,1'b1,1'b0,32'h0,        32'hFFFF_FFFF,5'd0, 5'd0, 5'd6, 32'h0,        32'h1234_5678};
        vecs[3] = '{1'b1,1'b1,1'b0,32'h0,        32'h0000_0011,5'd7, 5'd7, 5'd0, 32'h0000_0011,32'h0};
        vecs[4] = '{1'b0,1'b1,1'b0,32'h0,        32'h0000_0022,5'd7, 5'd7, 5'd5, 32'h0000_0011,32'h0000_00AA};
        vecs[5] = '{1'b1,1'b0,1'b0,32'h0,        32'h0000_0033,5'd7, 5'd5, 5'd7, 32'h0000_00AA,32'h0000_0011};
        vecs[6] = '{1'b1,1'b1,1'b1,32'h0000_0099,32'h0000_0044,5'd31,5'd31,5'd6, 32'h0000_0099,32'h1234_5678};
        vecs[7] = '{1'b1,1'b1,1'b0,32'h0,        32'h0000_0010,5'd3, 5'd3, 5'd31,32'h0000_0010,32'h0000_0099};

        #12;
        for (int i = 0; i < 32; i++) begin
            i_addr_a = 5'(i);
            i_addr_b = 5'(31 - i);
            #1;
            chk($sformatf("reset_rd_a[%0d]", i), o_data_a, 32'h0);
            chk($sformatf("reset_rd_b[%0d]", 31 - i), o_data_b, 32'h0);
        end
        chk("reset_valid", {31'h0, o_dump_valid}, 32'h0);
        chk("reset_done",  {31'h0, o_dump_done},  32'h0);
        chk("reset_index", {27'h0, o_dump_index}, 32'h0);
        chk("reset_data",  o_dump_data,           32'h0);

        @(negedge i_clk);
        i_reset = 1'b0;

        for (int v = 0; v < 8; v++) begin
            @(negedge i_clk);
            i_enable     = vecs[v].en;
            i_wb         = vecs[v].wb;
            i_mem_to_reg = vecs[v].m2r;
            i_mem_result = vecs[v].mem;
            i_alu_result = vecs[v].alu;
            i_addr_wr    = vecs[v].addr_wr;
            @(posedge i_clk);
            #1;
            i_wb     = 1'b0;
            i_enable = 1'b1;
            i_addr_a = vecs[v].addr_a;
            i_addr_b = vecs[v].addr_b;
            #1;
            chk($sformatf("vec%0d_a", v), o_data_a, vecs[v].exp_a);
            chk($sformatf("vec%0d_b", v), o_data_b, vecs[v].exp_b);
        end

        // Same-cycle write to reg3 (holds 0x10) while reading it.
        @(negedge i_clk);
        i_enable     = 1'b1;
        i_wb         = 1'b1;
        i_mem_to_reg = 1'b0;
        i_alu_result = 32'h55;
        i_addr_wr    = 5'd3;
        i_addr_a     = 5'd3;
        i_addr_b     = 5'd0;
        #1;
`ifdef REGBANK_WR_BYPASS_EN
        chk("bypass_same_cycle", o_data_a, 32'h55);
`else
        chk("nobypass_same_cycle", o_data_a, 32'h10);
`endif
        chk("bypass_idx0", o_data_b, 32'h0);
        @(posedge i_clk);
        #1 i_wb = 1'b0;
        #1 chk("write_next_cycle", o_data_a, 32'h55);
        @(negedge i_clk);
        i_enable = 1'b0;
        i_wb     = 1'b1;
        i_alu_result = 32'h77;
        #1 chk("no_bypass_when_disabled", o_data_a, 32'h55);
        @(posedge i_clk);
        #1;
        i_wb     = 1'b0;
        i_enable = 1'b1;
        #1 chk("disabled_write_dropped", o_data_a, 32'h55);

        // Full-rate dump of reg[i] = i*4.
        for (int i = 1; i < 32; i++) begin
            wr(5'(i), 32'(i * 4));
        end
        for (int i = 0; i < 32; i++) model[i] = 32'(i * 4);
        @(negedge i_clk);
        i_dump_start = 1'b1;
        i_dump_ready = 1'b1;
        @(negedge i_clk);
        i_dump_start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("dump_valid[%0d]", i), {31'h0, o_dump_valid}, 32'h1);
            chk($sformatf("dump_index[%0d]", i), {27'h0, o_dump_index}, 32'(i));
            chk($sformatf("dump_data[%0d]", i),  o_dump_data, model[i]);
            chk($sformatf("dump_nodone[%0d]", i), {31'h0, o_dump_done}, 32'h0);
            @(negedge i_clk);
        end
        chk("dump_done_pulse", {31'h0, o_dump_done},  32'h1);
        chk("dump_done_valid", {31'h0, o_dump_valid}, 32'h0);
        @(negedge i_clk);
        chk("dump_done_once",  {31'h0, o_dump_done},  32'h0);
        chk("dump_idle_valid", {31'h0, o_dump_valid}, 32'h0);

        // Backpressured dump, with reg8 rewritten while it is being held.
        begin
            int  exp_idx = 0;
            int  cyc     = 0;
            bit  wrote   = 0;
            logic rdy;
            i_dump_ready = 1'b0;
            i_dump_start = 1'b1;
            @(posedge i_clk);
            #1 i_dump_start = 1'b0;
            while (exp_idx < 32 && cyc < 200) begin
                @(negedge i_clk);
                chk($sformatf("bp_valid[%0d]", exp_idx), {31'h0, o_dump_valid}, 32'h1);
                chk($sformatf("bp_index[%0d]", exp_idx), {27'h0, o_dump_index}, 32'(exp_idx));
                chk($sformatf("bp_data[%0d]", exp_idx),  o_dump_data, model[exp_idx]);
                i_wb = 1'b0;
                rdy  = cyc[0];
                if (exp_idx == 8 && !rdy && !wrote) begin
                    i_enable     = 1'b1;
                    i_wb         = 1'b1;
                    i_mem_to_reg = 1'b0;
                    i_addr_wr    = 5'd8;
                    i_alu_result = 32'hDEAD_BEEF;
                    model[8]     = 32'hDEAD_BEEF;
                    wrote        = 1;
                end
                i_dump_ready = rdy;
                @(posedge i_clk);
                if (rdy) exp_idx++;
                cyc++;
            end
            i_wb = 1'b0;
            if (cyc >= 200) chk("bp_timeout", 32'(exp_idx), 32'd32);
            @(negedge i_clk);
            chk("bp_done_pulse", {31'h0, o_dump_done},  32'h1);
            chk("bp_done_valid", {31'h0, o_dump_valid}, 32'h0);
            @(negedge i_clk);
            chk("bp_done_once",  {31'h0, o_dump_done},  32'h0);
        end

        // Reset in the middle of a dump.
        i_dump_ready = 1'b1;
        i_dump_start = 1'b1;
        @(negedge i_clk);
        i_dump_start = 1'b0;
        for (int i = 0; i < 10; i++) @(negedge i_clk);
        chk("abort_at_index", {27'h0, o_dump_index}, 32'd10);
        #2 i_reset = 1'b1;
        #1;
        chk("abort_valid", {31'h0, o_dump_valid}, 32'h0);
        chk("abort_done",  {31'h0, o_dump_done},  32'h0);
        chk("abort_index", {27'h0, o_dump_index}, 32'h0);
        i_addr_a = 5'd5;
        #1 chk("abort_regs_cleared", o_data_a, 32'h0);
        @(negedge i_clk);
        chk("abort_no_done", {31'h0, o_dump_done}, 32'h0);
        i_reset = 1'b0;
        @(negedge i_clk);
        chk("abort_idle_done", {31'h0, o_dump_done}, 32'h0);
        i_dump_start = 1'b1;
        @(negedge i_clk);
        i_dump_start = 1'b0;
        i_dump_ready = 1'b0;
        chk("restart_valid", {31'h0, o_dump_valid}, 32'h1);
        chk("restart_index", {27'h0, o_dump_index}, 32'h0);
        chk("restart_data",  o_dump_data, 32'h0);
        @(negedge i_clk);
        chk("restart_hold_index", {27'h0, o_dump_index}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
